codificador: RTL and testbench

CODIFICADOR -- requirements
Module: codificador

---
 rtl/codificador.sv | 165 ++++++++++++++++
 tb/tb_codificador.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/codificador.sv
`default_nettype none
// ============================================================================
// codificador -- serialises C1..C(Destino) plus a terminator over a
// Valido/Aceito handshake. Optional macro: CODIFICADOR_INVALIDO_EN.
// Revision: 1.0
// ============================================================================
module codificador #(
  parameter int unsigned GAP = 0
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Controle,
  input  logic       Inicio,
  input  logic [2:0] Destino,
  input  logic       Aceito,
  output logic [6:0] Caractere,
  output logic       Valido,
  output logic       Pronto,
  output logic [3:0] Progresso,
  output logic       Fim,
  output logic       Erro
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENVIA    = 3'd1,
    PAUSA    = 3'd2,
    TERMINA  = 3'd3,
    INVALIDO = 3'd4
  } state_t;

  localparam logic [3:0] GAP_W    = 4'(GAP);
  localparam logic [2:0] IDX_TERM = 3'd6;
  localparam logic [6:0] C1 = 7'b1100000;
  localparam logic [6:0] C2 = 7'b1000100;
  localparam logic [6:0] C3 = 7'b1111100;
  localparam logic [6:0] C4 = 7'b1011010;
  localparam logic [6:0] C5 = 7'b1101110;
  localparam logic [6:0] C6 = 7'b1001001;
  localparam logic [6:0] C7 = 7'b1110101;
  localparam logic [6:0] C8 = 7'b1010011;

  state_t     state_q, state_d;
  logic [2:0] dest_q, dest_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [3:0] prog_q, prog_d;
  logic       erro_q, erro_d;
  logic       dest_ok;
  logic [6:0] char_w;

  assign dest_ok = (Destino != 3'd0) && (Destino <= 3'd5);

  // idx_q == IDX_TERM selects the terminator, chosen by the latched target
  always_comb begin
    char_w = 7'b0;
    case (idx_q)
      3'd1:    char_w = C1;
      3'd2:    char_w = C2;
      3'd3:    char_w = C3;
      3'd4:    char_w = C4;
      3'd5:    char_w = C5;
      default: char_w = (dest_q >= 3'd4) ? C8 : C6;
    endcase
  end

  // Controle low hides the character immediately, so no transfer can happen
  always_comb begin
    Valido    = 1'b0;
    Caractere = 7'b0;
    if (Controle) begin
      if (state_q == ENVIA) begin
        Valido    = 1'b1;
        Caractere = char_w;
      end else if (state_q == INVALIDO) begin
        Valido    = 1'b1;
        Caractere = C7;
      end
    end
  end

  assign Pronto    = (state_q == OCIOSO);
  assign Fim       = (state_q == TERMINA) && Controle;
  assign Progresso = prog_q;
  assign Erro      = erro_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    prog_d  = prog_q;
    erro_d  = 1'b0;
    if (Controle) begin
      case (state_q)
        OCIOSO: begin
          if (Inicio) begin
            if (dest_ok) begin
              state_d = ENVIA;
              dest_d  = Destino;
              idx_d   = 3'd1;
              prog_d  = 4'd0;
            end else begin
`ifdef CODIFICADOR_INVALIDO_EN
              state_d = INVALIDO;
              dest_d  = Destino;
              prog_d  = 4'd0;
`else
              erro_d  = 1'b1;
`endif
            end
          end
        end
        ENVIA: begin
          if (Aceito) begin
            if (idx_q == IDX_TERM) begin
              state_d = TERMINA;
            end else begin
              prog_d = prog_q + 4'd1;
              idx_d  = (idx_q == dest_q) ? IDX_TERM : idx_q + 3'd1;
              if (GAP_W != 4'd0) begin
                state_d = PAUSA;
                gap_d   = GAP_W - 4'd1;
              end
            end
          end
        end
        PAUSA: begin
          if (gap_q == 4'd0) begin
            state_d = ENVIA;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        TERMINA: state_d = OCIOSO;
        INVALIDO: begin
          if (Aceito) begin
            state_d = TERMINA;
          end
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= OCIOSO;
      dest_q  <= 3'd0;
      idx_q   <= 3'd0;
      gap_q   <= 4'd0;
      prog_q  <= 4'd0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      prog_q  <= prog_d;
      erro_q  <= erro_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codificador.sv
`default_nettype none
// tb_codificador -- directed bench with a character scoreboard per instance;
// dut_a runs with GAP=0, dut_b with GAP=2.
module tb_codificador;

  logic       clk   = 1'b0;
  logic       Reset = 1'b1;

  logic       ctl_a = 1'b0, ini_a = 1'b0, ace_a = 1'b0;
  logic [2:0] dst_a = 3'd0;
  logic [6:0] car_a;
  logic       val_a, pro_a, fim_a, err_a;
  logic [3:0] prg_a;

  logic       ctl_b = 1'b0, ini_b = 1'b0, ace_b = 1'b0;
  logic [2:0] dst_b = 3'd0;
  logic [6:0] car_b;
  logic       val_b, pro_b, fim_b, err_b;
  logic [3:0] prg_b;

  always #5 clk = ~clk;

  codificador #(.GAP(0)) dut_a (
    .clk(clk), .Reset(Reset), .Controle(ctl_a), .Inicio(ini_a), .Destino(dst_a),
    .Aceito(ace_a), .Caractere(car_a), .Valido(val_a), .Pronto(pro_a),
    .Progresso(prg_a), .Fim(fim_a), .Erro(err_a)
  );

  codificador #(.GAP(2)) dut_b (
    .clk(clk), .Reset(Reset), .Controle(ctl_b), .Inicio(ini_b), .Destino(dst_b),
    .Aceito(ace_b), .Caractere(car_b), .Valido(val_b), .Pronto(pro_b),
    .Progresso(prg_b), .Fim(fim_b), .Erro(err_b)
  );

  logic [6:0] q_a[$];
  logic [6:0] q_b[$];
  int checks = 0;
  int errors = 0;
  int fims_a = 0, fims_b = 0, vals_a = 0, erros_a = 0;

  logic [6:0] s_car_a;
  logic       s_val_a, s_pro_a, s_fim_a, s_err_a, s_val_b, s_fim_b;
  logic [3:0] s_prg_a, s_prg_b;

  function automatic logic [6:0] code(input int k);
    case (k)
      1:       return 7'b1100000;
      2:       return 7'b1000100;
      3:       return 7'b1111100;
      4:       return 7'b1011010;
      5:       return 7'b1101110;
      6:       return 7'b1001001;
      7:       return 7'b1110101;
      default: return 7'b1010011;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // expected transfer list for a transaction to target d
  task automatic push_a(input int d);
    for (int k = 1; k <= d; k++) q_a.push_back(code(k));
    q_a.push_back(d >= 4 ? code(8) : code(6));
  endtask

  // sample at negedge, score transfers that the coming posedge will make
  task automatic cyc();
    logic [6:0] e;
    @(negedge clk);
    s_car_a = car_a; s_val_a = val_a; s_pro_a = pro_a;
    s_fim_a = fim_a; s_err_a = err_a; s_prg_a = prg_a;
    s_val_b = val_b; s_fim_b = fim_b; s_prg_b = prg_b;
    if (val_a && ace_a) begin
      chk("sb_a_pending", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("sb_a_char", 32'(car_a), 32'(e));
      end
    end
    if (val_b && ace_b) begin
      chk("sb_b_pending", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("sb_b_char", 32'(car_b), 32'(e));
      end
    end
    if (fim_a) fims_a++;
    if (fim_b) fims_b++;
    if (val_a) vals_a++;
    if (err_a) erros_a++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fim_a(input int max_cyc);
    int base;
    int n;
    base = fims_a;
    n = 0;
    while (fims_a == base && n < max_cyc) begin
      cyc();
      n++;
    end
    chk("fim_a_seen", 32'(fims_a - base), 32'd1);
  endtask

  task automatic start_a(input logic [2:0] d);
    dst_a = d; ctl_a = 1'b1; ini_a = 1'b1; ace_a = 1'b1;
    cyc();
    ini_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    int base_v, base_f, base_e;

    // reset values
    #2 Reset = 1'b0;
    @(posedge clk); #1;
    cyc();
    chk("rst_caractere", 32'(s_car_a), 32'd0);
    chk("rst_valido", 32'(s_val_a), 32'd0);
    chk("rst_pronto", 32'(s_pro_a), 32'd1);
    chk("rst_progresso", 32'(s_prg_a), 32'd0);
    chk("rst_fim", 32'(s_fim_a), 32'd0);
    chk("rst_erro", 32'(s_err_a), 32'd0);
    Reset = 1'b1;
    cyc();

    // Destino=3, back-to-back C1,C2,C3,C6
    push_a(3);
    base_f = fims_a;
    start_a(3'd3);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_back_to_back", 32'(s_val_a), 32'd1);
    end
    cyc();
    chk("t1_fim", 32'(s_fim_a), 32'd1);
    chk("t1_progresso", 32'(s_prg_a), 32'd3);
    chk("t1_valido_low", 32'(s_val_a), 32'd0);
    cyc();
    chk("t1_pronto", 32'(s_pro_a), 32'd1);
    chk("t1_fim_once", 32'(fims_a - base_f), 32'd1);
    cyc();
    chk("t1_progresso_held", 32'(s_prg_a), 32'd3);

    // Destino=5 with Aceito held low on C2
    push_a(5);
    start_a(3'd5);
    cyc();
    chk("t2_progresso_cleared", 32'(s_prg_a), 32'd0);
    ace_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_hold_c2", 32'(s_car_a), 32'(code(2)));
      chk("t2_hold_valido", 32'(s_val_a), 32'd1);
    end
    ace_a = 1'b1;
    wait_fim_a(12);
    chk("t2_progresso", 32'(s_prg_a), 32'd5);
    chk("t2_sb_empty", 32'(q_a.size()), 32'd0);
    cyc();

    // GAP=2, Destino=2 on dut_b
    q_b.push_back(code(1));
    q_b.push_back(code(2));
    q_b.push_back(code(6));
    dst_b = 3'd2; ctl_b = 1'b1; ini_b = 1'b1; ace_b = 1'b1;
    cyc();
    ini_b = 1'b0;
    pat = 7'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      pat[6-i] = s_val_b;
    end
    chk("t3_gap_pattern", 32'(pat), 32'b1001001);
    cyc();
    chk("t3_fim", 32'(s_fim_b), 32'd1);
    chk("t3_progresso", 32'(s_prg_b), 32'd2);
    chk("t3_sb_empty", 32'(q_b.size()), 32'd0);
    ctl_b = 1'b0;

    // Controle low for 4 cycles while C3 of Destino=4 is pending
    push_a(4);
    start_a(3'd4);
    cyc();
    cyc();
    ctl_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_paused_valido", 32'(s_val_a), 32'd0);
      chk("t4_paused_pronto", 32'(s_pro_a), 32'd0);
    end
    ctl_a = 1'b1;
    cyc();
    chk("t4_resume_c3", 32'(s_car_a), 32'(code(3)));
    wait_fim_a(10);
    chk("t4_progresso", 32'(s_prg_a), 32'd4);
    chk("t4_sb_empty", 32'(q_a.size()), 32'd0);
    cyc();

    // Destino=7
    base_v = vals_a;
    base_e = erros_a;
`ifdef CODIFICADOR_INVALIDO_EN
    q_a.push_back(code(7));
    start_a(3'd7);
    wait_fim_a(6);
    chk("t5_progresso_zero", 32'(s_prg_a), 32'd0);
    chk("t5_one_valido", 32'(vals_a - base_v), 32'd1);
    chk("t5_no_erro", 32'(erros_a - base_e), 32'd0);
    chk("t5_sb_empty", 32'(q_a.size()), 32'd0);
`else
    start_a(3'd7);
    cyc();
    chk("t5_erro_pulse", 32'(s_err_a), 32'd1);
    chk("t5_pronto", 32'(s_pro_a), 32'd1);
    cyc();
    chk("t5_erro_cleared", 32'(s_err_a), 32'd0);
    cyc();
    chk("t5_no_valido", 32'(vals_a - base_v), 32'd0);
    chk("t5_one_erro", 32'(erros_a - base_e), 32'd1);
`endif
    cyc();

    // asynchronous reset while C2 is pending
    push_a(2);
    start_a(3'd2);
    cyc();
    ace_a = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("t6_async_valido", 32'(val_a), 32'd0);
    chk("t6_async_pronto", 32'(pro_a), 32'd1);
    chk("t6_async_progresso", 32'(prg_a), 32'd0);
    q_a.delete();
    base_f = fims_a;
    @(posedge clk); #1;
    cyc();
    Reset = 1'b1;
    cyc();
    chk("t6_no_fim", 32'(fims_a - base_f), 32'd0);
    chk("t6_idle_pronto", 32'(s_pro_a), 32'd1);
    push_a(1);
    start_a(3'd1);
    wait_fim_a(6);
    chk("t6_progresso", 32'(s_prg_a), 32'd1);
    chk("t6_sb_empty", 32'(q_a.size()), 32'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
